// File: rtl/pe_pkg.sv
// pe_pkg: shared constants and FSM state type for the PE operand loader
package pe_pkg;
  localparam int LANES = 16;
  localparam int DW = 8;
  localparam int RW = 16;
  localparam int IW = $clog2(LANES);
  localparam int CW = 5;
  localparam int FRAME_FULL = 32;
  localparam int FRAME_IN = 16;
  typedef enum logic [1:0] {LOAD_I, LOAD_W, CAPTURE, OUT} state_t;
endpackage

// File: rtl/pe_lane_regfile.sv
// pe_lane_regfile: LANES x DW operand bank, one lane written per cycle
// ports: clk, rst_n (async low), we/idx/wdata write port, vec = packed lanes (lane k at [k*DW +: DW])
module pe_lane_regfile #(
  parameter int LANES = 16,
  parameter int DW = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(LANES)-1:0] idx,
  input  logic [DW-1:0]            wdata,
  output logic [LANES*DW-1:0]      vec
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vec <= '0;
    else if (we) vec[idx*DW +: DW] <= wdata;
endmodule

// File: rtl/pe_operand_loader.sv
// pe_operand_loader: assembles a byte stream into PE operand vectors and returns the PE result
// ports: clk, rst_n (async low); s_data/s_valid/s_last/s_ready byte stream in;
//   i_vec/w_vec operand vectors to the PE; pe_result combinational PE output;
//   m_data/m_valid/m_ready result out; err_pulse one-cycle framing error
// option: PE_LOADER_WT_KEEP_EN adds wt_keep (sampled with byte 0) for 16-byte input-only frames
module pe_operand_loader
  import pe_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DW-1:0]       s_data,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
`ifdef PE_LOADER_WT_KEEP_EN
  input  logic                wt_keep,
`endif
  output logic [LANES*DW-1:0] i_vec,
  output logic [LANES*DW-1:0] w_vec,
  input  logic [RW-1:0]       pe_result,
  output logic [RW-1:0]       m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                err_pulse
);
  state_t state;
  logic [CW-1:0] cnt;
  logic fire, final_byte;
  assign s_ready = state == LOAD_I || state == LOAD_W;
  assign fire = s_valid && s_ready;
`ifdef PE_LOADER_WT_KEEP_EN
  logic keep_q, keep_now;
  // the keep flag travels with byte 0, so use the live input until it is registered
  assign keep_now = cnt == '0 ? wt_keep : keep_q;
  assign final_byte = cnt == (keep_now ? CW'(FRAME_IN - 1) : CW'(FRAME_FULL - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) keep_q <= 1'b0;
    else if (fire && cnt == '0) keep_q <= wt_keep;
`else
  assign final_byte = cnt == CW'(FRAME_FULL - 1);
`endif
  // lane index for weights is cnt-16, which is simply the low bits of cnt
  pe_lane_regfile #(.LANES(LANES), .DW(DW)) u_in (
    .clk(clk), .rst_n(rst_n), .we(fire && state == LOAD_I),
    .idx(cnt[IW-1:0]), .wdata(s_data), .vec(i_vec)
  );
  pe_lane_regfile #(.LANES(LANES), .DW(DW)) u_wt (
    .clk(clk), .rst_n(rst_n), .we(fire && state == LOAD_W),
    .idx(cnt[IW-1:0]), .wdata(s_data), .vec(w_vec)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= LOAD_I;
      cnt <= '0;
      m_data <= '0;
      m_valid <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        LOAD_I, LOAD_W: if (fire) begin
          if (final_byte) begin
            state <= CAPTURE;
            cnt <= '0;
            err_pulse <= !s_last;
          end else if (s_last) begin
            // early last aborts the frame but keeps whatever lanes were written
            state <= LOAD_I;
            cnt <= '0;
            err_pulse <= 1'b1;
          end else begin
            state <= cnt == CW'(FRAME_IN - 1) ? LOAD_W : state;
            cnt <= cnt + CW'(1);
          end
        end
        CAPTURE: begin
          m_data <= pe_result;
          m_valid <= 1'b1;
          state <= OUT;
        end
        OUT: if (m_ready) begin
          m_valid <= 1'b0;
          state <= LOAD_I;
        end
        default: state <= LOAD_I;
      endcase
    end
endmodule
